// File: rtl/tt_spine_pkg.sv
// Shared definitions for the spine controller and the row muxes: opcodes,
// sequencer states, address field layout and spine bit offsets.
package tt_spine_pkg;

  localparam int ADDR_W   = 10;
  localparam int ROW_MSB  = 9;
  localparam int ROW_LSB  = 6;
  localparam int BANK_BIT = 5;
  localparam int COL_MSB  = 4;

  // spine_iw = {gh, usr, sel, ena, gl}; spine_ow = {gh, usr, gl}
  localparam int IW_GL      = 0;
  localparam int IW_ENA     = 1;
  localparam int IW_SEL_LSB = 2;
  localparam int OW_GL      = 0;
  localparam int OW_USR_LSB = 1;

  typedef enum logic [1:0] {
    OP_CLR  = 2'd0,
    OP_INC  = 2'd1,
    OP_LOAD = 2'd2,
    OP_OFF  = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_DROP   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_ON     = 2'd3
  } seq_state_e;

  function automatic logic [ADDR_W-1:0] next_addr(input cmd_op_e op,
                                                  input logic [ADDR_W-1:0] cur,
                                                  input logic [ADDR_W-1:0] ld);
    case (op)
      OP_CLR:  next_addr = '0;
      OP_INC:  next_addr = cur + 10'd1;
      OP_LOAD: next_addr = ld;
      default: next_addr = cur;
    endcase
  endfunction

endpackage

// File: rtl/tt_spine_seq.sv
// Enable sequencer: drops ena before any address change, then holds the new
// address with ena low for SETTLE_CYCLES before re-enabling.
module tt_spine_seq
  import tt_spine_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accept_i,
  input  logic [1:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              on_o,
  output logic              off_o
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ld_q, ld_d;
  cmd_op_e           op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  cmd_op_e           op_in;

  assign op_in = cmd_op_e'(op_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      addr_q  <= '0;
      ld_q    <= '0;
      op_q    <= OP_CLR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ld_q    <= ld_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ld_d    = ld_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_OFF: begin
        if (accept_i && op_in != OP_OFF) begin
          addr_d  = next_addr(op_in, addr_q, addr_i);
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          state_d = ST_SETTLE;
        end
      end
      ST_ON: begin
        // Command is parked for the DROP cycle so the old address stays put.
        if (accept_i) begin
          op_d    = op_in;
          ld_d    = addr_i;
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (op_q == OP_OFF) begin
          state_d = ST_OFF;
        end else begin
          addr_d  = next_addr(op_q, addr_q, ld_q);
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_ON;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_OFF;
    endcase
  end

  assign addr_o = addr_q;
  assign on_o   = (state_q == ST_ON);
  assign off_o  = (state_q == ST_OFF);

endmodule

// File: rtl/tt_spine_ctrl.sv
// Spine root controller: registers every spine_iw bit, forwards pad inputs
// onto the spine and masks the returned outputs while no design is enabled.
module tt_spine_ctrl
  import tt_spine_pkg::*;
#(
  parameter  int N_IO          = 8,
  parameter  int N_O           = 8,
  parameter  int N_I           = 10,
  parameter  int SETTLE_CYCLES = 4,
  localparam int U_OW          = N_O + 2 * N_IO,
  localparam int U_IW          = N_I + N_IO,
  localparam int S_OW          = U_OW + 2,
  localparam int S_IW          = U_IW + 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [U_IW-1:0]   pad_in,
  output logic [U_OW-1:0]   pad_out,
  output logic [S_IW-1:0]   spine_iw,
  input  logic [S_OW-1:0]   spine_ow,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              active
);

  logic              accept;
  logic [ADDR_W-1:0] seq_addr;
  logic              seq_on, seq_off;
  logic              ena_q;
  logic [ADDR_W-1:0] sel_q;
  logic [U_IW-1:0]   usr_q;
  logic              unused_ow;

  // The first ON cycle is not ready: ena reaches the spine one cycle later.
  assign cmd_ready = seq_off | (seq_on & ena_q);
  assign accept    = cmd_valid & cmd_ready;

  tt_spine_seq #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .accept_i (accept),
    .op_i     (cmd_op),
    .addr_i   (cmd_addr),
    .addr_o   (seq_addr),
    .on_o     (seq_on),
    .off_o    (seq_off)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ena_q <= 1'b0;
      sel_q <= '0;
      usr_q <= '0;
    end else begin
      ena_q <= seq_on;
      sel_q <= seq_addr;
      usr_q <= pad_in;
    end
  end

  assign spine_iw  = {1'b0, usr_q, sel_q, ena_q, 1'b0};
  assign cur_addr  = sel_q;
  assign active    = ena_q;

  // Returned usr floats when no row matches, so it is only trusted while enabled.
  assign pad_out   = ena_q ? spine_ow[OW_USR_LSB +: U_OW] : '0;
  assign unused_ow = spine_ow[S_OW-1] ^ spine_ow[OW_GL];

endmodule

// File: tb/tb_tt_spine_ctrl.sv
// Scoreboard bench for tt_spine_ctrl: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the spine and pad outputs.
module tb_tt_spine_ctrl;

  localparam logic [1:0] CLR = 2'd0, INC = 2'd1, LOAD = 2'd2, OFF = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [9:0]  cmd_addr = 10'd0;
  logic [17:0] pad_in;
  logic [23:0] pad_out;
  logic [30:0] spine_iw;
  logic [25:0] spine_ow;
  logic [9:0]  cur_addr;
  logic        active;

  typedef struct packed {
    logic [31:0] id;
    logic [9:0]  sel;
    logic        ena;
    logic        rdy;
    logic [23:0] pout;
    logic [17:0] usr;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_id  = 0;
  int          pat   = 0;
  logic [17:0] pin_tbl [4] = '{18'h2A5A5, 18'h15A5A, 18'h3FFFF, 18'h00001};
  logic [23:0] ow_tbl  [4] = '{24'hC3C3C3, 24'h3C3C3C, 24'hFFFFFF, 24'h5A0F96};
  logic [23:0] ow_usr;

  tt_spine_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .pad_in    (pad_in),
    .pad_out   (pad_out),
    .spine_iw  (spine_iw),
    .spine_ow  (spine_ow),
    .cur_addr  (cur_addr),
    .active    (active)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [9:0] sel, input logic ena, input logic rdy,
                      input logic [23:0] pout, input logic [17:0] usr);
    exp_t e;
    e.id = n_id; e.sel = sel; e.ena = ena; e.rdy = rdy; e.pout = pout; e.usr = usr;
    n_id++;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] id,
                     input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s #%0d: got %h expected %h", nm, id, act, exp);
    end
  endtask

  // Apply a command, clock once, then queue the state expected after that edge.
  task automatic step(input logic v, input logic [1:0] op, input logic [9:0] a,
                      input logic [9:0] esel, input logic eena, input logic erdy);
    logic [17:0] usr_e;
    cmd_valid = v; cmd_op = op; cmd_addr = a;
    usr_e = rst_n ? pad_in : 18'h0;
    @(posedge clk); #1;
    pat++;
    pad_in   = pin_tbl[pat % 4];
    ow_usr   = ow_tbl[pat % 4];
    spine_ow = {1'b1, ow_usr, 1'b1};
    push(esel, eena, erdy, eena ? ow_usr : 24'h0, usr_e);
  endtask

  task automatic idle(input logic [9:0] esel, input logic eena, input logic erdy);
    step(1'b0, CLR, 10'h0, esel, eena, erdy);
  endtask

  // Accepted from OFF at edge T: sel new after T+1, ena high after T+5.
  task automatic off_seq(input logic [1:0] op, input logic [9:0] a,
                         input logic [9:0] old_a, input logic [9:0] new_a);
    step(1'b1, op, a, old_a, 1'b0, 1'b0);
    repeat (4) idle(new_a, 1'b0, 1'b0);
    idle(new_a, 1'b1, 1'b1);
  endtask

  // Accepted from ON at edge T: ena low after T+1, sel new after T+2, ena high after T+6.
  task automatic on_seq(input logic [1:0] op, input logic [9:0] a,
                        input logic [9:0] old_a, input logic [9:0] new_a);
    step(1'b1, op, a, old_a, 1'b1, 1'b0);
    idle(old_a, 1'b0, 1'b0);
    repeat (4) idle(new_a, 1'b0, 1'b0);
    idle(new_a, 1'b1, 1'b1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sel",      e.id, 32'(spine_iw[11:2]), 32'(e.sel));
        chk("cur_addr", e.id, 32'(cur_addr),       32'(e.sel));
        chk("ena",      e.id, 32'(spine_iw[1]),    32'(e.ena));
        chk("active",   e.id, 32'(active),         32'(e.ena));
        chk("ready",    e.id, 32'(cmd_ready),      32'(e.rdy));
        chk("pad_out",  e.id, 32'(pad_out),        32'(e.pout));
        chk("usr",      e.id, 32'(spine_iw[29:12]), 32'(e.usr));
        chk("guards",   e.id, 32'({spine_iw[30], spine_iw[0]}), 32'd0);
      end
    end
  end

  initial begin : stim
    pad_in   = pin_tbl[0];
    ow_usr   = ow_tbl[0];
    spine_ow = {1'b1, ow_usr, 1'b1};
    repeat (2) begin
      @(posedge clk); #1;
      push(10'h0, 1'b0, 1'b1, 24'h0, 18'h0);
    end
    rst_n = 1'b1;
    idle(10'h000, 1'b0, 1'b1);

    off_seq(LOAD, 10'h2C5, 10'h000, 10'h2C5);
    idle(10'h2C5, 1'b1, 1'b1);
    idle(10'h2C5, 1'b1, 1'b1);
    on_seq(LOAD, 10'h3FF, 10'h2C5, 10'h3FF);
    on_seq(INC,  10'h000, 10'h3FF, 10'h000);

    // OFF from ON: one DROP cycle then OFF, address kept, pads masked.
    step(1'b1, OFF, 10'h0, 10'h000, 1'b1, 1'b0);
    idle(10'h000, 1'b0, 1'b1);
    idle(10'h000, 1'b0, 1'b1);
    step(1'b1, OFF, 10'h0, 10'h000, 1'b0, 1'b1);
    idle(10'h000, 1'b0, 1'b1);

    off_seq(INC, 10'h0, 10'h000, 10'h001);
    on_seq(CLR,  10'h2AA, 10'h001, 10'h000);
    on_seq(LOAD, 10'h000, 10'h000, 10'h000);

    // INC held valid through a LOAD sequence: taken only once ready returns.
    step(1'b1, LOAD, 10'h100, 10'h000, 1'b1, 1'b0);
    step(1'b1, INC,  10'h0,   10'h000, 1'b0, 1'b0);
    repeat (4) step(1'b1, INC, 10'h0, 10'h100, 1'b0, 1'b0);
    step(1'b1, INC, 10'h0, 10'h100, 1'b1, 1'b1);
    step(1'b1, INC, 10'h0, 10'h100, 1'b1, 1'b0);
    idle(10'h100, 1'b0, 1'b0);
    repeat (4) idle(10'h101, 1'b0, 1'b0);
    idle(10'h101, 1'b1, 1'b1);

    // Reset asserted mid-SETTLE, away from any clock edge.
    step(1'b1, LOAD, 10'h155, 10'h101, 1'b1, 1'b0);
    idle(10'h101, 1'b0, 1'b0);
    idle(10'h155, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    push(10'h0, 1'b0, 1'b1, 24'h0, 18'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    off_seq(LOAD, 10'h2AA, 10'h000, 10'h2AA);
    idle(10'h2AA, 1'b1, 1'b1);

    cmd_valid = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
